uart_tx_driver: RTL and testbench

Memory-mapped UART transmitter peripheral that drives oFpgaUartToPc, which is currently tied off. It is the CPU-to-PC counterpart of the UART programmer receive path. The CPU writes bytes through the IOWrite path when the UART chip-select is asserted. Bytes are buffered in a small FIFO and serialised as 8N1 frames, LSB first. The CPU polls a status halfword through the IORead path to pace its writes.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx_driver.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit peripheral: FSM encoding, register map, status layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] UART_DATA = 2'b00;
    localparam logic [1:0] UART_CTRL = 2'b01;
    localparam logic [1:0] UART_STAT = 2'b10;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // Status has a 4-bit count field; deeper FIFOs report 15 when fuller than that.
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_driver.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, FSM serialises them LSB first.
// Latency: push at edge N into an idle, empty path pops at N+1; start bit drives the line from N+1.
// Backpressure: none on the bus; CPU polls status, bytes written into a full FIFO set sticky overflow.
module uart_tx_driver
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 8
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iDoUartWrite,
    input  logic        iDoUartRead,
    input  logic [1:0]  iUartAddress,
    input  logic [7:0]  iUartDataToWrite,
    output logic [15:0] oUartReadData,
    output logic        oFpgaUartToPc
);

    localparam int                FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q;
    tx_state_t         state_nxt;
    logic [CNT_W-1:0]  baud_q;
    logic [CNT_W-1:0]  baud_nxt;
    logic [2:0]        idx_q;
    logic [2:0]        idx_nxt;
    logic [7:0]        shift_q;
    logic [7:0]        shift_nxt;
    logic              tx_q;
    logic              tx_nxt;
    logic              baud_last;

    logic              wr_data_vld;
    logic              wr_ctrl_vld;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_cnt;
    logic [7:0]        fifo_head;
    logic              ovf_q;
    logic              ovf_set;
    logic              busy;
    logic [15:0]       stat_dat;
    logic [15:0]       rd_dat_q;

    assign wr_data_vld = iDoUartWrite && (iUartAddress == UART_DATA);
    assign wr_ctrl_vld = iDoUartWrite && (iUartAddress == UART_CTRL);
    assign fifo_push   = wr_data_vld && (!fifo_full || fifo_pop);
    assign ovf_set     = wr_data_vld && fifo_full && !fifo_pop;
    assign baud_last   = (baud_q == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk      (iCpuClock),
        .rst_n    (iCpuReset),
        .push_vld (fifo_push),
        .push_dat (iUartDataToWrite),
        .pop_rdy  (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_nxt;
            baud_q  <= baud_nxt;
            idx_q   <= idx_nxt;
            shift_q <= shift_nxt;
            tx_q    <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        baud_nxt  = baud_q;
        idx_nxt   = idx_q;
        shift_nxt = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_START;
                    baud_nxt  = '0;
                    idx_nxt   = '0;
                    shift_nxt = fifo_head;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift_q[7:1]};
                    idx_nxt   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    baud_nxt = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
                if (baud_last) begin
                    baud_nxt = '0;
                    if (!fifo_empty) begin
                        state_nxt = ST_START;
                        idx_nxt   = '0;
                        shift_nxt = fifo_head;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud_q + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line value is precomputed from the next state so the pin comes straight off a flop.
    always_comb begin
        fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
        busy     = (state_q != ST_IDLE) || !fifo_empty;
        unique case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (wr_ctrl_vld && iUartDataToWrite[0]) begin
            ovf_q <= 1'b0;
        end
    end

    always_comb begin
        stat_dat                           = '0;
        stat_dat[STAT_BUSY]                = busy;
        stat_dat[STAT_FULL]                = fifo_full;
        stat_dat[STAT_EMPTY]               = fifo_empty;
        stat_dat[STAT_OVF]                 = ovf_q;
        stat_dat[STAT_CNT_LSB+3:STAT_CNT_LSB] = sat_count4(32'(fifo_cnt));
    end

    always_ff @(posedge iCpuClock or negedge iCpuReset) begin
        if (!iCpuReset) begin
            rd_dat_q <= '0;
        end else if (iDoUartRead && (iUartAddress == UART_STAT)) begin
            rd_dat_q <= stat_dat;
        end else begin
            rd_dat_q <= '0;
        end
    end

    assign oUartReadData = rd_dat_q;
    assign oFpgaUartToPc = tx_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
// Bench for uart_tx_driver: directed scenarios plus random bus traffic against a frame-timing model.
// The model tracks a byte queue and the cycle offset into the current frame.
module tb_uart_tx_driver;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        do_wr  = 1'b0;
    logic        do_rd  = 1'b0;
    logic [1:0]  addr   = 2'b00;
    logic [7:0]  wdat   = 8'h00;
    logic [15:0] rdat;
    logic        txd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_driver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (8)
    ) dut (
        .iCpuClock        (clk),
        .iCpuReset        (rst_n),
        .iDoUartWrite     (do_wr),
        .iDoUartRead      (do_rd),
        .iUartAddress     (addr),
        .iUartDataToWrite (wdat),
        .oUartReadData    (rdat),
        .oFpgaUartToPc    (txd)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued bytes, frame offset (-1 when idle), byte in flight, sticky overflow.
    logic [7:0]  mq [$];
    int          frame_t = -1;
    logic [7:0]  cur     = 8'h00;
    bit          m_ovf   = 1'b0;
    logic [15:0] m_rd    = 16'h0000;

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        int          n;
        n     = mq.size();
        s     = 16'h0000;
        s[0]  = (frame_t >= 0) || (n > 0);
        s[1]  = (n == DEPTH);
        s[2]  = (n == 0);
        s[3]  = m_ovf;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    function automatic logic m_line();
        int b;
        if (frame_t < 0) return 1'b1;
        b = frame_t / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit          pop;
        bit          ovf_set;
        logic [15:0] st;
        if (!rst_n) begin
            mq.delete();
            frame_t = -1;
            m_ovf   = 1'b0;
            m_rd    = 16'h0000;
        end else begin
            st      = m_status();
            pop     = (mq.size() > 0) && ((frame_t < 0) || (frame_t == FRAME - 1));
            ovf_set = do_wr && (addr == 2'b00) && (mq.size() == DEPTH) && !pop;
            if (pop) begin
                cur     = mq.pop_front();
                frame_t = 0;
            end else if (frame_t == FRAME - 1) begin
                frame_t = -1;
            end else if (frame_t >= 0) begin
                frame_t++;
            end
            if (do_wr && (addr == 2'b00) && !ovf_set) mq.push_back(wdat);
            if (ovf_set) m_ovf = 1'b1;
            else if (do_wr && (addr == 2'b01) && wdat[0]) m_ovf = 1'b0;
            m_rd = (do_rd && (addr == 2'b10)) ? st : 16'h0000;
        end
    end

    always @(negedge clk) begin
        check("line", {15'b0, txd}, {15'b0, m_line()});
        check("rdata", rdat, m_rd);
    end

    task automatic cyc(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        do_wr = w;
        do_rd = r;
        addr  = a;
        wdat  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic rd_stat(output logic [15:0] v);
        cyc(1'b0, 1'b1, 2'b10, 8'h00);
        v = rdat;
    endtask

    initial begin
        logic [15:0] st;
        int          r;

        @(negedge clk);
        idle(2);
        check("reset_line", {15'b0, txd}, 16'h0001);
        check("reset_rdata", rdat, 16'h0000);
        rst_n = 1'b1;
        idle(2);
        rd_stat(st);
        check("idle_status", st, 16'h0004);

        // Single frame 0x55: start bit for edges N+1..N+4, then LSB=1.
        cyc(1'b1, 1'b0, 2'b00, 8'h55);
        check("f1_pre_start", {15'b0, txd}, 16'h0001);
        idle(1);
        check("f1_start_first", {15'b0, txd}, 16'h0000);
        idle(3);
        check("f1_start_last", {15'b0, txd}, 16'h0000);
        idle(1);
        check("f1_bit0", {15'b0, txd}, 16'h0001);
        rd_stat(st);
        check("f1_busy_status", st, 16'h0005);
        idle(40);
        rd_stat(st);
        check("f1_done_status", st, 16'h0004);

        // Two back-to-back frames.
        cyc(1'b1, 1'b0, 2'b00, 8'hA3);
        cyc(1'b1, 1'b0, 2'b00, 8'h0F);
        idle(FRAME);
        check("f2_second_start", {15'b0, txd}, 16'h0000);
        idle(FRAME + 5);
        rd_stat(st);
        check("f2_done_status", st, 16'h0004);

        // Fill FIFO, then overflow.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 2'b00, 8'(8'h30 + i));
        idle(5);
        cyc(1'b1, 1'b0, 2'b00, 8'hEE);
        rd_stat(st);
        check("ovf_status", st, 16'h008B);
        cyc(1'b1, 1'b0, 2'b01, 8'h02);
        rd_stat(st);
        check("ovf_kept_bit0_zero", st, 16'h008B);
        cyc(1'b1, 1'b0, 2'b01, 8'h01);
        rd_stat(st);
        check("ovf_cleared", st, 16'h0083);
        cyc(1'b1, 1'b0, 2'b10, 8'h77);
        cyc(1'b1, 1'b0, 2'b11, 8'h77);
        cyc(1'b0, 1'b1, 2'b00, 8'h00);
        check("read_addr00", rdat, 16'h0000);
        cyc(1'b0, 1'b1, 2'b11, 8'h00);
        check("read_addr11", rdat, 16'h0000);
        rd_stat(st);
        check("ignored_writes", st, 16'h0083);
        idle(9 * FRAME + 10);
        rd_stat(st);
        check("drained_status", st, 16'h0004);

        // Async reset during data bit 3 of 0x55 (a zero bit).
        cyc(1'b1, 1'b0, 2'b00, 8'h55);
        idle(17);
        check("pre_reset_bit3", {15'b0, txd}, 16'h0000);
        #2 rst_n = 1'b0;
        #1 check("async_reset_line", {15'b0, txd}, 16'h0001);
        @(negedge clk);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        rd_stat(st);
        check("post_reset_status", st, 16'h0004);
        idle(FRAME + 5);

        // Random bus traffic.
        repeat (3000) begin
            r = int'($urandom_range(0, 15));
            if (r < 2)       cyc(1'b1, 1'b0, 2'b00, 8'($urandom));
            else if (r == 2) cyc(1'b1, 1'b0, 2'($urandom_range(1, 3)), 8'($urandom));
            else if (r == 3) cyc(1'b0, 1'b1, 2'($urandom), 8'h00);
            else             idle(1);
        end
        cyc(1'b1, 1'b0, 2'b01, 8'h01);
        idle(400);
        rd_stat(st);
        check("final_status", st, 16'h0004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
